wb_stage: RTL and testbench

- Writeback stage of the 5-stage RV32I pipeline; the producer end of the register-file write port that the decode stage consumes (RegWrite / rd_addr / rd_data).
- Holds the MEM/WB pipeline register and extends load data.
- Merges results from a long-latency side unit (multiply/divide) through a 2-entry queue.
- Pipeline writes have priority over side-unit writes; also maintains the retired-instruction counter.

---
 rtl/wb_stage_pkg.sv | 33 +++
 rtl/wb_side_fifo.sv | 60 ++++++
 rtl/wb_stage.sv | 159 +++++++++++++++
 tb/tb_wb_stage.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_stage_pkg.sv
// Shared writeback-stage types: result-select and load-type encodings plus the
// MEM/WB flow bundle carried from the memory stage.
package wb_stage_pkg;

  localparam int WB_XLEN = 32;

  typedef enum logic [1:0] {
    WB_SEL_ALU  = 2'd0,
    WB_SEL_LOAD = 2'd1,
    WB_SEL_PC4  = 2'd2,
    WB_SEL_RSVD = 2'd3
  } wb_sel_e;

  typedef enum logic [2:0] {
    LT_LB  = 3'b000,
    LT_LH  = 3'b001,
    LT_LW  = 3'b010,
    LT_LBU = 3'b100,
    LT_LHU = 3'b101
  } load_type_e;

  // load_type is kept as raw funct3 so unsupported encodings survive the register
  typedef struct packed {
    logic                 reg_write;
    logic [4:0]           rd;
    wb_sel_e              wb_sel;
    logic [2:0]           load_type;
    logic [WB_XLEN-1:0]   alu_result;
    logic [WB_XLEN-1:0]   pc_plus4;
    logic [WB_XLEN-1:0]   load_data;
  } mem_wb_t;

endpackage

// File: rtl/wb_side_fifo.sv
// Small FIFO holding side-unit (mul/div) results until the register-file
// write port is free; valid/ready on the push side, pop/empty on the drain side.
module wb_side_fifo #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push_valid_i,
  output logic                         push_ready_o,
  input  logic [4:0]                   push_rd_i,
  input  logic [DATA_W-1:0]            push_data_i,
  input  logic                         pop_i,
  output logic                         empty_o,
  output logic [4:0]                   head_rd_o,
  output logic [DATA_W-1:0]            head_data_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [4:0]        rd_mem   [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic              push, pop;

  assign push_ready_o = (count_q != CW'(DEPTH));
  assign empty_o      = (count_q == '0);
  assign push         = push_valid_i & push_ready_o;
  assign pop          = pop_i & ~empty_o;
  assign head_rd_o    = rd_mem[rd_ptr_q];
  assign head_data_o  = data_mem[rd_ptr_q];
  assign count_o      = count_q;

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem[wr_ptr_q]   <= push_rd_i;
      data_mem[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/wb_stage.sv
// RV32I writeback stage: MEM/WB register, load extension, arbitration between
// pipeline and queued side-unit results for the single register-file write port.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int XLEN       = WB_XLEN,
  parameter int SIDE_DEPTH = 2
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              stall,
  input  logic                              flush,
  input  logic                              in_valid,
  input  logic                              in_reg_write,
  input  logic [4:0]                        in_rd_addr,
  input  logic [1:0]                        in_wb_sel,
  input  logic [XLEN-1:0]                   in_alu_result,
  input  logic [XLEN-1:0]                   in_pc_plus4,
  input  logic [XLEN-1:0]                   in_load_data,
  input  logic [2:0]                        in_load_type,
  input  logic                              lu_valid,
  output logic                              lu_ready,
  input  logic [4:0]                        lu_rd_addr,
  input  logic [XLEN-1:0]                   lu_data,
  output logic                              RegWrite,
  output logic [4:0]                        rd_addr,
  output logic [XLEN-1:0]                   rd_data,
  output logic                              retire_valid,
  output logic [63:0]                       instret,
  output logic [$clog2(SIDE_DEPTH+1)-1:0]   side_count
);

  mem_wb_t           mw_q, mw_d, mw_in;
  logic              wb_valid_q, wb_valid_d;
  logic              done_q, done_d;
  logic [63:0]       instret_q;
  logic              pipe_fire, pipe_wr;
  logic              side_empty, side_pop, side_wr;
  logic [4:0]        side_rd;
  logic [XLEN-1:0]   side_data;
  logic [XLEN-1:0]   result;

  function automatic logic [XLEN-1:0] load_ext(input logic [2:0]      lt,
                                                input logic [1:0]      lane,
                                                input logic [XLEN-1:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (lt)
      LT_LB:   return {{(XLEN-8){b[7]}}, b};
      LT_LH:   return {{(XLEN-16){h[15]}}, h};
      LT_LW:   return word;
      LT_LBU:  return {{(XLEN-8){1'b0}}, b};
      LT_LHU:  return {{(XLEN-16){1'b0}}, h};
      default: return '0;
    endcase
  endfunction

  always_comb begin
    mw_in.reg_write  = in_reg_write;
    mw_in.rd         = in_rd_addr;
    mw_in.wb_sel     = wb_sel_e'(in_wb_sel);
    mw_in.load_type  = in_load_type;
    mw_in.alu_result = in_alu_result;
    mw_in.pc_plus4   = in_pc_plus4;
    mw_in.load_data  = in_load_data;
  end

  // done marks an instruction that already fired while held by stall
  always_comb begin
    mw_d       = mw_q;
    wb_valid_d = wb_valid_q;
    done_d     = done_q;
    if (flush) begin
      wb_valid_d = 1'b0;
      done_d     = 1'b0;
    end else if (stall) begin
      done_d     = wb_valid_q;
    end else begin
      mw_d       = mw_in;
      wb_valid_d = in_valid;
      done_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_valid_q <= 1'b0;
      done_q     <= 1'b0;
      instret_q  <= '0;
    end else begin
      wb_valid_q <= wb_valid_d;
      done_q     <= done_d;
      instret_q  <= instret_q + {63'd0, pipe_fire};
    end
  end

  always_ff @(posedge clk) begin
    mw_q <= mw_d;
  end

  assign pipe_fire = wb_valid_q & ~done_q;
  assign pipe_wr   = pipe_fire & mw_q.reg_write & (mw_q.rd != 5'd0);

  always_comb begin
    case (mw_q.wb_sel)
      WB_SEL_ALU:  result = mw_q.alu_result;
      WB_SEL_LOAD: result = load_ext(mw_q.load_type, mw_q.alu_result[1:0], mw_q.load_data);
      WB_SEL_PC4:  result = mw_q.pc_plus4;
      default:     result = '0;
    endcase
  end

  wb_side_fifo #(
    .DEPTH  (SIDE_DEPTH),
    .DATA_W (XLEN)
  ) u_side_fifo (
    .clk          (clk),
    .rst_n        (reset),
    .push_valid_i (lu_valid),
    .push_ready_o (lu_ready),
    .push_rd_i    (lu_rd_addr),
    .push_data_i  (lu_data),
    .pop_i        (side_pop),
    .empty_o      (side_empty),
    .head_rd_o    (side_rd),
    .head_data_o  (side_data),
    .count_o      (side_count)
  );

  // Side entries drain only into cycles the pipeline leaves free; x0 entries vanish
  assign side_pop = ~side_empty & ~pipe_wr;
  assign side_wr  = side_pop & (side_rd != 5'd0);

  always_comb begin
    RegWrite = 1'b0;
    rd_addr  = '0;
    rd_data  = '0;
    if (pipe_wr) begin
      RegWrite = 1'b1;
      rd_addr  = mw_q.rd;
      rd_data  = result;
    end else if (side_wr) begin
      RegWrite = 1'b1;
      rd_addr  = side_rd;
      rd_data  = side_data;
    end
  end

  assign retire_valid = pipe_fire;
  assign instret      = instret_q;

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: expected register-file writes are queued as
// stimulus is driven and matched against the write port every cycle.
`timescale 1ns/1ps
module tb_wb_stage;

  localparam int XLEN = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              stall, flush;
  logic              in_valid, in_reg_write;
  logic [4:0]        in_rd_addr;
  logic [1:0]        in_wb_sel;
  logic [XLEN-1:0]   in_alu_result, in_pc_plus4, in_load_data;
  logic [2:0]        in_load_type;
  logic              lu_valid, lu_ready;
  logic [4:0]        lu_rd_addr;
  logic [XLEN-1:0]   lu_data;
  logic              RegWrite;
  logic [4:0]        rd_addr;
  logic [XLEN-1:0]   rd_data;
  logic              retire_valid;
  logic [63:0]       instret;
  logic [1:0]        side_count;

  int                checks = 0;
  int                errors = 0;
  logic [36:0]       exp_q[$];
  longint unsigned   exp_instret = 0;
  int                retire_seen = 0;

  wb_stage #(.XLEN(XLEN), .SIDE_DEPTH(2)) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_reg_write  (in_reg_write),
    .in_rd_addr    (in_rd_addr),
    .in_wb_sel     (in_wb_sel),
    .in_alu_result (in_alu_result),
    .in_pc_plus4   (in_pc_plus4),
    .in_load_data  (in_load_data),
    .in_load_type  (in_load_type),
    .lu_valid      (lu_valid),
    .lu_ready      (lu_ready),
    .lu_rd_addr    (lu_rd_addr),
    .lu_data       (lu_data),
    .RegWrite      (RegWrite),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .retire_valid  (retire_valid),
    .instret       (instret),
    .side_count    (side_count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // Write-port monitor: every write must match the head of the scoreboard
  always @(negedge clk) begin : monitor
    logic [36:0] e;
    if (reset) begin
      if (retire_valid) retire_seen++;
      checks++;
      if (RegWrite) begin
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: got rd=%0d data=%h, required no write", rd_addr, rd_data);
        end else begin
          e = exp_q.pop_front();
          if ({rd_addr, rd_data} !== e) begin
            errors++;
            $display("FAIL write_port: got rd=%0d data=%h, required rd=%0d data=%h",
                     rd_addr, rd_data, e[36:32], e[31:0]);
          end
        end
      end else if (rd_addr !== 5'd0 || rd_data !== '0) begin
        errors++;
        $display("FAIL idle_port: got rd=%0d data=%h, required 0/0", rd_addr, rd_data);
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic rw, input logic [4:0] rd, input logic [1:0] sel,
                       input logic [31:0] alu, input logic [31:0] pc4,
                       input logic [31:0] ld, input logic [2:0] lt);
    in_valid      = 1'b1;
    in_reg_write  = rw;
    in_rd_addr    = rd;
    in_wb_sel     = sel;
    in_alu_result = alu;
    in_pc_plus4   = pc4;
    in_load_data  = ld;
    in_load_type  = lt;
    exp_instret++;
    cycle();
  endtask

  task automatic drain(input string name);
    in_valid = 1'b0;
    lu_valid = 1'b0;
    stall    = 1'b0;
    flush    = 1'b0;
    cycle();
    cycle();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    cycle();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d writes outstanding, required 0", name, exp_q.size());
    end
    checks++;
    if (instret !== exp_instret) begin
      errors++;
      $display("FAIL %s_instret: got %0d, required %0d", name, instret, exp_instret);
    end
    checks++;
    if (retire_seen !== int'(exp_instret)) begin
      errors++;
      $display("FAIL %s_retires: got %0d, required %0d", name, retire_seen, exp_instret);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    stall = 1'b0; flush = 1'b0; in_valid = 1'b0; in_reg_write = 1'b0;
    in_rd_addr = '0; in_wb_sel = '0; in_alu_result = '0; in_pc_plus4 = '0;
    in_load_data = '0; in_load_type = '0; lu_valid = 1'b0; lu_rd_addr = '0; lu_data = '0;
    repeat (3) cycle();
    checks++;
    if ({RegWrite, rd_addr, rd_data, retire_valid, instret, lu_ready, side_count} !==
        {1'b0, 5'd0, 32'd0, 1'b0, 64'd0, 1'b1, 2'd0}) begin
      errors++;
      $display("FAIL reset_held: we=%b rd=%0d data=%h ret=%b instret=%0d ready=%b cnt=%0d, required 0s and ready=1",
               RegWrite, rd_addr, rd_data, retire_valid, instret, lu_ready, side_count);
    end
    reset = 1'b1;
    cycle();
    checks++;
    if ({RegWrite, rd_addr, rd_data, retire_valid, instret, lu_ready, side_count} !==
        {1'b0, 5'd0, 32'd0, 1'b0, 64'd0, 1'b1, 2'd0}) begin
      errors++;
      $display("FAIL reset_released: we=%b rd=%0d data=%h ret=%b instret=%0d ready=%b cnt=%0d, required 0s and ready=1",
               RegWrite, rd_addr, rd_data, retire_valid, instret, lu_ready, side_count);
    end
  endtask

  task automatic test_load();
    exp_q.push_back({5'd5, 32'hFFFF_FF80});
    issue(1'b1, 5'd5, 2'd1, 32'h0000_1003, 32'h0, 32'h80FF_0000, 3'b000);
    exp_q.push_back({5'd5, 32'h0000_0080});
    issue(1'b1, 5'd5, 2'd1, 32'h0000_1003, 32'h0, 32'h80FF_0000, 3'b100);
    exp_q.push_back({5'd6, 32'h0000_80FF});
    issue(1'b1, 5'd6, 2'd1, 32'h0000_1002, 32'h0, 32'h80FF_0000, 3'b101);
    exp_q.push_back({5'd7, 32'hFFFF_8001});
    issue(1'b1, 5'd7, 2'd1, 32'h0000_1001, 32'h0, 32'h1234_8001, 3'b001);
    exp_q.push_back({5'd8, 32'h0000_007F});
    issue(1'b1, 5'd8, 2'd1, 32'h0000_2001, 32'h0, 32'h0000_7F00, 3'b000);
    exp_q.push_back({5'd9, 32'hCAFE_F00D});
    issue(1'b1, 5'd9, 2'd1, 32'h0000_2000, 32'h0, 32'hCAFE_F00D, 3'b010);
    exp_q.push_back({5'd10, 32'h0});
    issue(1'b1, 5'd10, 2'd1, 32'h0000_2000, 32'h0, 32'hCAFE_F00D, 3'b011);
    exp_q.push_back({5'd11, 32'h0});
    issue(1'b1, 5'd11, 2'd3, 32'h0000_1234, 32'h5678, 32'h9ABC, 3'b010);
    exp_q.push_back({5'd12, 32'h0000_1234});
    issue(1'b1, 5'd12, 2'd0, 32'h0000_1234, 32'h5678, 32'h9ABC, 3'b010);
    drain("load");
  endtask

  task automatic test_side_priority();
    lu_valid = 1'b1; lu_rd_addr = 5'd7; lu_data = 32'hDEAD_BEEF;
    exp_q.push_back({5'd1, 32'h11});
    exp_q.push_back({5'd2, 32'h22});
    exp_q.push_back({5'd7, 32'hDEAD_BEEF});
    issue(1'b1, 5'd1, 2'd0, 32'h11, 32'h0, 32'h0, 3'b010);
    lu_valid = 1'b0;
    checks++;
    if (side_count !== 2'd1) begin
      errors++;
      $display("FAIL side_held_1: side_count=%0d, required 1", side_count);
    end
    issue(1'b1, 5'd2, 2'd0, 32'h22, 32'h0, 32'h0, 3'b010);
    checks++;
    if (side_count !== 2'd1 || rd_addr !== 5'd2) begin
      errors++;
      $display("FAIL side_held_2: side_count=%0d rd=%0d, required 1 and rd=2", side_count, rd_addr);
    end
    in_valid = 1'b0;
    cycle();
    checks++;
    if ({RegWrite, rd_addr, rd_data} !== {1'b1, 5'd7, 32'hDEAD_BEEF}) begin
      errors++;
      $display("FAIL side_drain: we=%b rd=%0d data=%h, required 1/7/deadbeef", RegWrite, rd_addr, rd_data);
    end
    drain("side_priority");
  endtask

  task automatic test_back_to_back();
    int   si;
    logic acc;
    si = 0;
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back({5'(10 + k), 32'(32'h1000 + k)});
      lu_valid   = (si < 3);
      lu_rd_addr = 5'(20 + si);
      lu_data    = 32'(32'hA000_0000 + si);
      acc = lu_ready;
      if (k >= 2) begin
        checks++;
        if (acc !== 1'b0) begin
          errors++;
          $display("FAIL b2b_ready_full: lu_ready=%b at k=%0d, required 0", acc, k);
        end
      end
      issue(1'b1, 5'(10 + k), 2'd0, 32'(32'h1000 + k), 32'h0, 32'h0, 3'b010);
      if (acc) si++;
    end
    checks++;
    if (si !== 2 || side_count !== 2'd2) begin
      errors++;
      $display("FAIL b2b_accepted: accepted=%0d side_count=%0d, required 2 and 2", si, side_count);
    end
    for (int j = 0; j < 3; j++) exp_q.push_back({5'(20 + j), 32'(32'hA000_0000 + j)});
    in_valid = 1'b0;
    for (int t = 0; t < 10 && si < 3; t++) begin
      lu_valid   = 1'b1;
      lu_rd_addr = 5'(20 + si);
      lu_data    = 32'(32'hA000_0000 + si);
      acc = lu_ready;
      cycle();
      if (acc) si++;
    end
    lu_valid = 1'b0;
    checks++;
    if (si !== 3) begin
      errors++;
      $display("FAIL b2b_third: accepted=%0d, required 3", si);
    end
    drain("b2b");
  endtask

  task automatic test_jal_stall();
    exp_q.push_back({5'd1, 32'h0000_0104});
    issue(1'b1, 5'd1, 2'd2, 32'h0000_0099, 32'h0000_0104, 32'h0, 3'b010);
    stall = 1'b1;
    in_valid = 1'b1; in_reg_write = 1'b1; in_rd_addr = 5'd9; in_alu_result = 32'h999;
    in_wb_sel = 2'd0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if (RegWrite !== 1'b0 || retire_valid !== 1'b0) begin
        errors++;
        $display("FAIL jal_stall_hold: cycle %0d we=%b ret=%b, required 0/0", i, RegWrite, retire_valid);
      end
    end
    stall = 1'b0;
    in_valid = 1'b0;
    cycle();
    drain("jal_stall");
  endtask

  task automatic test_flush();
    flush = 1'b1; stall = 1'b1;
    in_valid = 1'b1; in_reg_write = 1'b1; in_rd_addr = 5'd4; in_wb_sel = 2'd0;
    cycle();
    flush = 1'b0; stall = 1'b0; in_valid = 1'b0;
    checks++;
    if (RegWrite !== 1'b0 || retire_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_bubble: we=%b ret=%b, required 0/0", RegWrite, retire_valid);
    end
    drain("flush");
  endtask

  task automatic test_x0();
    issue(1'b1, 5'd0, 2'd0, 32'h77, 32'h0, 32'h0, 3'b010);
    checks++;
    if (RegWrite !== 1'b0 || retire_valid !== 1'b1) begin
      errors++;
      $display("FAIL x0_pipe: we=%b ret=%b, required 0/1", RegWrite, retire_valid);
    end
    in_valid = 1'b0;
    lu_valid = 1'b1; lu_rd_addr = 5'd0; lu_data = 32'h55;
    cycle();
    lu_valid = 1'b0;
    checks++;
    if (side_count !== 2'd1 || RegWrite !== 1'b0) begin
      errors++;
      $display("FAIL x0_side_pop: side_count=%0d we=%b, required 1/0", side_count, RegWrite);
    end
    cycle();
    checks++;
    if (side_count !== 2'd0) begin
      errors++;
      $display("FAIL x0_side_gone: side_count=%0d, required 0", side_count);
    end
    drain("x0");
  endtask

  task automatic test_reset_mid();
    lu_valid = 1'b1; lu_rd_addr = 5'd8; lu_data = 32'h8888;
    exp_q.push_back({5'd3, 32'h33});
    issue(1'b1, 5'd3, 2'd0, 32'h33, 32'h0, 32'h0, 3'b010);
    lu_rd_addr = 5'd9; lu_data = 32'h9999;
    exp_q.push_back({5'd4, 32'h44});
    issue(1'b1, 5'd4, 2'd0, 32'h44, 32'h0, 32'h0, 3'b010);
    lu_valid = 1'b0; in_valid = 1'b0;
    checks++;
    if (side_count !== 2'd2) begin
      errors++;
      $display("FAIL rstmid_fill: side_count=%0d, required 2", side_count);
    end
    @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    checks++;
    if ({side_count, instret, lu_ready, RegWrite, retire_valid} !== {2'd0, 64'd0, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL rstmid_clear: cnt=%0d instret=%0d ready=%b we=%b ret=%b, required 0/0/1/0/0",
               side_count, instret, lu_ready, RegWrite, retire_valid);
    end
    exp_instret = 0;
    retire_seen = 0;
    cycle();
    reset = 1'b1;
    cycle();
    exp_q.push_back({5'd2, 32'h2});
    issue(1'b1, 5'd2, 2'd0, 32'h2, 32'h0, 32'h0, 3'b010);
    drain("rstmid");
  endtask

  initial begin
    test_reset();
    test_load();
    test_side_priority();
    test_back_to_back();
    test_jal_stall();
    test_flush();
    test_x0();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
